// File: rtl/rr_interval_tracker.sv
// RR interval tracker: measures beat-to-beat time in ms; rr_valid rises 3 edges after pulse_in is sampled high.
// Unaccepted data is overwritten, which sets the sticky overrun flag. Define RR_AVG_EN to build the running average.
module rr_interval_tracker #(
   parameter int CNT_W         = 12,
   parameter int TICKS_PER_MS  = 1000,
   parameter int AVG_LOG2      = 3,
   parameter int REFRACTORY_MS = 200
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pulse_in,
   input  logic             rr_ready,
   output logic             rr_valid,
   output logic [CNT_W-1:0] rr_ms,
   output logic [CNT_W-1:0] rr_avg_ms,
   output logic             timeout,
   output logic             overrun
);

   localparam int               PRE_W    = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(TICKS_PER_MS - 1);
   localparam logic [CNT_W-1:0] MS_MAX   = '1;
   localparam logic [CNT_W-1:0] REFRACT  = CNT_W'(REFRACTORY_MS);

   typedef enum logic [1:0] {
      WAIT_FIRST = 2'd0,
      MEASURE    = 2'd1,
      TIMEOUT    = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       sync_q;
   logic             beat_q;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic [CNT_W-1:0] ms_q, ms_d, ms_inc;
   logic             pre_wrap;
   logic             capture;
   logic             rr_valid_q, rr_valid_d;
   logic [CNT_W-1:0] rr_ms_q, rr_ms_d;
   logic             overrun_q, overrun_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= WAIT_FIRST;
         sync_q     <= '0;
         beat_q     <= 1'b0;
         pre_q      <= '0;
         ms_q       <= '0;
         rr_valid_q <= 1'b0;
         rr_ms_q    <= '0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync_q     <= {sync_q[1:0], pulse_in};
         // Registered edge detect adds the third stage of beat latency
         beat_q     <= sync_q[1] & ~sync_q[2];
         pre_q      <= pre_d;
         ms_q       <= ms_d;
         rr_valid_q <= rr_valid_d;
         rr_ms_q    <= rr_ms_d;
         overrun_q  <= overrun_d;
      end
   end

   always_comb begin
      pre_wrap = (pre_q == PRE_MAX);
      // Interval is taken as the count including this edge's tick, so N ms of cycles reads as N
      ms_inc   = (pre_wrap && (ms_q != MS_MAX)) ? ms_q + 1'b1 : ms_q;
      pre_d    = pre_wrap ? '0 : pre_q + 1'b1;
      ms_d     = ms_inc;
      state_d  = state_q;
      capture  = 1'b0;
      case (state_q)
         WAIT_FIRST: begin
            if (beat_q) begin
               pre_d   = '0;
               ms_d    = '0;
               state_d = MEASURE;
            end
         end
         MEASURE: begin
            if (beat_q && (ms_inc >= REFRACT)) begin
               capture = 1'b1;
               pre_d   = '0;
               ms_d    = '0;
            end else if (ms_q == MS_MAX) begin
               state_d = TIMEOUT;
            end
         end
         TIMEOUT: begin
            if (beat_q) begin
               pre_d   = '0;
               ms_d    = '0;
               state_d = MEASURE;
            end
         end
         default: state_d = WAIT_FIRST;
      endcase
      rr_valid_d = capture | (rr_valid_q & ~rr_ready);
      overrun_d  = overrun_q | (capture & rr_valid_q & ~rr_ready);
      rr_ms_d    = capture ? ms_inc : rr_ms_q;
   end

`ifdef RR_AVG_EN
   localparam int DEPTH = 1 << AVG_LOG2;
   localparam int SUM_W = CNT_W + AVG_LOG2;

   logic [CNT_W-1:0]    avg_buf_q [DEPTH];
   logic [AVG_LOG2-1:0] avg_ptr_q;
   logic [SUM_W-1:0]    sum_q, sum_d;
   logic [CNT_W-1:0]    avg_q;

   // Sum always equals the buffer contents, so the subtraction never underflows
   assign sum_d = sum_q + SUM_W'(ms_inc) - SUM_W'(avg_buf_q[avg_ptr_q]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) avg_buf_q[i] <= '0;
         avg_ptr_q <= '0;
         sum_q     <= '0;
         avg_q     <= '0;
      end else if (capture) begin
         avg_buf_q[avg_ptr_q] <= ms_inc;
         avg_ptr_q            <= avg_ptr_q + 1'b1;
         sum_q                <= sum_d;
         avg_q                <= sum_d[SUM_W-1:AVG_LOG2];
      end
   end

   assign rr_avg_ms = avg_q;
`else
   assign rr_avg_ms = '0;
`endif

   assign rr_valid = rr_valid_q;
   assign rr_ms    = rr_ms_q;
   assign timeout  = (state_q == TIMEOUT);
   assign overrun  = overrun_q;

endmodule

// File: tb/tb_rr_interval_tracker.sv
// Scoreboard bench for rr_interval_tracker at 4 clk/ms: expected intervals are queued as beats are driven
// and compared against every accepted handshake captured by the monitor.
module tb_rr_interval_tracker;

   localparam int TPM = 4;
`ifdef RR_AVG_EN
   localparam bit AVG_ON = 1'b1;
`else
   localparam bit AVG_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pulse_in = 1'b0;
   logic        rr_ready = 1'b0;
   logic        rr_valid;
   logic [11:0] rr_ms;
   logic [11:0] rr_avg_ms;
   logic        timeout;
   logic        overrun;

   int          n_tests = 0;
   int          n_fail = 0;
   int          vld_rises = 0;
   logic        prev_vld = 1'b0;
   logic [11:0] exp_ms[$], exp_avg[$], got_ms[$], got_avg[$];
   int          mbuf[8];
   int          mptr = 0;
   int          msum = 0;

   rr_interval_tracker #(
      .CNT_W(12), .TICKS_PER_MS(TPM), .AVG_LOG2(3), .REFRACTORY_MS(200)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .rr_ready(rr_ready),
      .rr_valid(rr_valid), .rr_ms(rr_ms), .rr_avg_ms(rr_avg_ms),
      .timeout(timeout), .overrun(overrun)
   );

   always #5 clk = ~clk;

   // Monitor: inputs change at posedge+2, so the falling edge sees stable handshake values
   always @(negedge clk) begin
      if (rr_valid && rr_ready) begin
         got_ms.push_back(rr_ms);
         got_avg.push_back(rr_avg_ms);
      end
      if (rr_valid && !prev_vld) vld_rises++;
      prev_vld = rr_valid;
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic beat_gap(input int ms);
      pulse_in = 1'b1;
      wait_cyc(2);
      pulse_in = 1'b0;
      wait_cyc(ms * TPM - 2);
   endtask

   task automatic model_add(input int ms, output logic [11:0] avg);
      msum = msum + ms - mbuf[mptr];
      mbuf[mptr] = ms;
      mptr = (mptr + 1) % 8;
      avg = AVG_ON ? 12'(msum / 8) : 12'd0;
   endtask

   task automatic expect_iv(input int ms);
      logic [11:0] a;
      model_add(ms, a);
      exp_ms.push_back(12'(ms));
      exp_avg.push_back(a);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      pulse_in = 1'b0;
      wait_cyc(2);
      rst_n = 1'b1;
      foreach (mbuf[i]) mbuf[i] = 0;
      mptr = 0;
      msum = 0;
      exp_ms.delete(); exp_avg.delete(); got_ms.delete(); got_avg.delete();
      wait_cyc(2);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      wait_cyc(2);
      n_tests++; if (rr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", rr_valid); end
      n_tests++; if (rr_ms !== 12'd0) begin n_fail++; $display("FAIL reset_ms: got %0d want 0", rr_ms); end
      n_tests++; if (rr_avg_ms !== 12'd0) begin n_fail++; $display("FAIL reset_avg: got %0d want 0", rr_avg_ms); end
      n_tests++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", timeout); end
      n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
      rst_n = 1'b1;
      wait_cyc(2);
   endtask

   task automatic test_first_interval();
      int v0;
      do_reset();
      rr_ready = 1'b1;
      v0 = vld_rises;
      beat_gap(1000);
      expect_iv(1000);
      pulse_in = 1'b1;
      wait_cyc(2);
      pulse_in = 1'b0;
      wait_cyc(1);
      n_tests++; if (rr_valid !== 1'b0) begin n_fail++; $display("FAIL latency_early: valid %b after 2nd edge, want 0", rr_valid); end
      wait_cyc(1);
      n_tests++; if (rr_valid !== 1'b1) begin n_fail++; $display("FAIL latency_3rd: valid %b after 3rd edge, want 1", rr_valid); end
      n_tests++; if (rr_ms !== 12'd1000) begin n_fail++; $display("FAIL first_ms: got %0d want 1000", rr_ms); end
      n_tests++; if (rr_avg_ms !== (AVG_ON ? 12'd125 : 12'd0)) begin n_fail++; $display("FAIL first_avg: got %0d want %0d", rr_avg_ms, AVG_ON ? 125 : 0); end
      wait_cyc(5);
      n_tests++; if (vld_rises - v0 !== 1) begin n_fail++; $display("FAIL first_pulses: got %0d valid pulses want 1", vld_rises - v0); end
      n_tests++; if (got_ms.size() != exp_ms.size()) begin n_fail++; $display("FAIL first_count: got %0d want %0d", got_ms.size(), exp_ms.size()); end
      while (got_ms.size() > 0 && exp_ms.size() > 0) begin
         logic [11:0] gm, ga, em, ea;
         gm = got_ms.pop_front(); ga = got_avg.pop_front(); em = exp_ms.pop_front(); ea = exp_avg.pop_front();
         n_tests++; if (gm !== em || ga !== ea) begin n_fail++; $display("FAIL first_sb: got ms=%0d avg=%0d want ms=%0d avg=%0d", gm, ga, em, ea); end
      end
   endtask

   task automatic test_average();
      int v0;
      do_reset();
      rr_ready = 1'b1;
      v0 = vld_rises;
      for (int i = 0; i < 9; i++) begin
         if (i > 0) expect_iv(800);
         if (i == 4) begin
            beat_gap(100);
            beat_gap(700);
         end else if (i == 8) begin
            beat_gap(20);
         end else begin
            beat_gap(800);
         end
      end
      n_tests++; if (vld_rises - v0 !== 8) begin n_fail++; $display("FAIL avg_pulses: got %0d want 8", vld_rises - v0); end
      n_tests++; if (rr_avg_ms !== (AVG_ON ? 12'd800 : 12'd0)) begin n_fail++; $display("FAIL avg_final: got %0d want %0d", rr_avg_ms, AVG_ON ? 800 : 0); end
      n_tests++; if (got_ms.size() != exp_ms.size()) begin n_fail++; $display("FAIL avg_count: got %0d want %0d", got_ms.size(), exp_ms.size()); end
      while (got_ms.size() > 0 && exp_ms.size() > 0) begin
         logic [11:0] gm, ga, em, ea;
         gm = got_ms.pop_front(); ga = got_avg.pop_front(); em = exp_ms.pop_front(); ea = exp_avg.pop_front();
         n_tests++; if (gm !== em || ga !== ea) begin n_fail++; $display("FAIL avg_sb: got ms=%0d avg=%0d want ms=%0d avg=%0d", gm, ga, em, ea); end
      end
   endtask

   task automatic test_timeout();
      int v0;
      do_reset();
      rr_ready = 1'b1;
      v0 = vld_rises;
      beat_gap(4090);
      n_tests++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got %b at 4090 ms want 0", timeout); end
      wait_cyc(10 * TPM);
      n_tests++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_set: got %b at 4100 ms want 1", timeout); end
      beat_gap(600);
      n_tests++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_clear: got %b after beat want 0", timeout); end
      n_tests++; if (vld_rises - v0 !== 0) begin n_fail++; $display("FAIL timeout_discard: got %0d valid pulses want 0", vld_rises - v0); end
      expect_iv(600);
      beat_gap(10);
      n_tests++; if (vld_rises - v0 !== 1) begin n_fail++; $display("FAIL timeout_resume: got %0d valid pulses want 1", vld_rises - v0); end
      n_tests++; if (got_ms.size() != exp_ms.size()) begin n_fail++; $display("FAIL timeout_count: got %0d want %0d", got_ms.size(), exp_ms.size()); end
      while (got_ms.size() > 0 && exp_ms.size() > 0) begin
         logic [11:0] gm, ga, em, ea;
         gm = got_ms.pop_front(); ga = got_avg.pop_front(); em = exp_ms.pop_front(); ea = exp_avg.pop_front();
         n_tests++; if (gm !== em || ga !== ea) begin n_fail++; $display("FAIL timeout_sb: got ms=%0d avg=%0d want ms=%0d avg=%0d", gm, ga, em, ea); end
      end
   endtask

   task automatic test_overrun();
      logic [11:0] lost;
      do_reset();
      rr_ready = 1'b0;
      beat_gap(500);
      model_add(500, lost);
      beat_gap(700);
      n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_early: got %b want 0", overrun); end
      expect_iv(700);
      beat_gap(10);
      n_tests++; if (rr_valid !== 1'b1) begin n_fail++; $display("FAIL overrun_valid: got %b want 1", rr_valid); end
      n_tests++; if (rr_ms !== 12'd700) begin n_fail++; $display("FAIL overrun_ms: got %0d want 700", rr_ms); end
      n_tests++; if (rr_avg_ms !== (AVG_ON ? 12'd150 : 12'd0)) begin n_fail++; $display("FAIL overrun_avg: got %0d want %0d", rr_avg_ms, AVG_ON ? 150 : 0); end
      n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %b want 1", overrun); end
      rr_ready = 1'b1;
      wait_cyc(2);
      n_tests++; if (rr_valid !== 1'b0) begin n_fail++; $display("FAIL overrun_accept: valid %b want 0", rr_valid); end
      n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky: got %b want 1", overrun); end
      n_tests++; if (got_ms.size() != exp_ms.size()) begin n_fail++; $display("FAIL overrun_count: got %0d want %0d", got_ms.size(), exp_ms.size()); end
      while (got_ms.size() > 0 && exp_ms.size() > 0) begin
         logic [11:0] gm, ga, em, ea;
         gm = got_ms.pop_front(); ga = got_avg.pop_front(); em = exp_ms.pop_front(); ea = exp_avg.pop_front();
         n_tests++; if (gm !== em || ga !== ea) begin n_fail++; $display("FAIL overrun_sb: got ms=%0d avg=%0d want ms=%0d avg=%0d", gm, ga, em, ea); end
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      rr_ready = 1'b0;
      beat_gap(300);
      expect_iv(300);
      beat_gap(400);
      expect_iv(400);
      // Accept lands on the same edge the 400 ms interval is captured
      pulse_in = 1'b1;
      wait_cyc(2);
      pulse_in = 1'b0;
      wait_cyc(1);
      rr_ready = 1'b1;
      wait_cyc(1);
      n_tests++; if (rr_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b want 1", rr_valid); end
      n_tests++; if (rr_ms !== 12'd400) begin n_fail++; $display("FAIL b2b_ms: got %0d want 400", rr_ms); end
      n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
      wait_cyc(3);
      n_tests++; if (got_ms.size() != exp_ms.size()) begin n_fail++; $display("FAIL b2b_count: got %0d want %0d", got_ms.size(), exp_ms.size()); end
      while (got_ms.size() > 0 && exp_ms.size() > 0) begin
         logic [11:0] gm, ga, em, ea;
         gm = got_ms.pop_front(); ga = got_avg.pop_front(); em = exp_ms.pop_front(); ea = exp_avg.pop_front();
         n_tests++; if (gm !== em || ga !== ea) begin n_fail++; $display("FAIL b2b_sb: got ms=%0d avg=%0d want ms=%0d avg=%0d", gm, ga, em, ea); end
      end
   endtask

   task automatic test_reset_mid();
      int v0;
      do_reset();
      rr_ready = 1'b0;
      beat_gap(500);
      beat_gap(300);
      n_tests++; if (rr_valid !== 1'b1 || rr_ms !== 12'd500) begin n_fail++; $display("FAIL rmid_pre: valid=%b ms=%0d want 1/500", rr_valid, rr_ms); end
      rst_n = 1'b0;
      #1;
      n_tests++; if ({rr_valid, rr_ms, rr_avg_ms, timeout, overrun} !== 27'd0) begin
         n_fail++; $display("FAIL rmid_async: valid=%b ms=%0d avg=%0d to=%b ov=%b want all 0", rr_valid, rr_ms, rr_avg_ms, timeout, overrun);
      end
      do_reset();
      rr_ready = 1'b1;
      v0 = vld_rises;
      beat_gap(900);
      expect_iv(900);
      beat_gap(10);
      n_tests++; if (vld_rises - v0 !== 1) begin n_fail++; $display("FAIL rmid_pulses: got %0d want 1", vld_rises - v0); end
      n_tests++; if (got_ms.size() != exp_ms.size()) begin n_fail++; $display("FAIL rmid_count: got %0d want %0d", got_ms.size(), exp_ms.size()); end
      while (got_ms.size() > 0 && exp_ms.size() > 0) begin
         logic [11:0] gm, ga, em, ea;
         gm = got_ms.pop_front(); ga = got_avg.pop_front(); em = exp_ms.pop_front(); ea = exp_avg.pop_front();
         n_tests++; if (gm !== em || ga !== ea) begin n_fail++; $display("FAIL rmid_sb: got ms=%0d avg=%0d want ms=%0d avg=%0d", gm, ga, em, ea); end
      end
   endtask

   initial begin
      test_reset();
      test_first_interval();
      test_average();
      test_timeout();
      test_overrun();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
